// File: rtl/c_buffer_drain_if.sv
// Interface bundling the drain control, the C buffer port and the output word stream of
// c_buffer_drain.
//   Control : start, base_index, row_count (to drain); busy, done (from drain)
//   C port  : C_wr_en, C_index, C_data_in (from drain); C_data_out (to drain)
//   Stream  : out_valid, out_data, out_last (from drain); out_ready (to drain)
// The master modport is the drain block; the slave modport is its environment.
interface c_buffer_drain_if #(
  parameter int unsigned IDX_W = 16
) ();
  logic             start;
  logic [IDX_W-1:0] base_index;
  logic [IDX_W-1:0] row_count;
  logic             busy;
  logic             done;
  logic             C_wr_en;
  logic [IDX_W-1:0] C_index;
  logic [127:0]     C_data_in;
  logic [127:0]     C_data_out;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;

  modport master (
    input  start, base_index, row_count, C_data_out, out_ready,
    output busy, done, C_wr_en, C_index, C_data_in, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_index, row_count, C_data_out, out_ready,
    input  busy, done, C_wr_en, C_index, C_data_in, out_valid, out_data, out_last
  );
endinterface

// File: rtl/c_buffer_drain.sv
// Reads 128-bit rows back from the C global buffer and serialises each into four 32-bit beats
// (most-significant lane first) on a valid/ready stream.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : c_buffer_drain_if.master (control, C buffer read port, output stream)
// A 1-cycle-latency read feeds an output shift register plus a one-row prefetch register so
// that a ready sink sees one beat per cycle.
module c_buffer_drain #(
  parameter int unsigned IDX_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  c_buffer_drain_if.master  bus
);
  localparam int unsigned LANES = 4;
  localparam int unsigned LaneW = 32;
  localparam int unsigned RowW  = LANES * LaneW;

  typedef enum logic [1:0] {StIdle, StFill, StStream, StFinish} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  c_index_q, c_index_d;
  logic [IDX_W-1:0]  next_idx_q, next_idx_d;
  logic [IDX_W-1:0]  issue_cnt_q, issue_cnt_d;   // reads still to issue
  logic [IDX_W-1:0]  rows_left_q, rows_left_d;   // rows not yet fully streamed
  logic [1:0]        committed_q, committed_d;   // rows buffered or in flight (max 2)
  logic              rd_q, rd_d;                 // read address presented this cycle
  logic              dv_q, dv_d;                 // read data present on C_data_out
  logic [RowW-1:0]   shift_q, shift_d;
  logic [1:0]        lane_q, lane_d;
  logic              shift_vld_q, shift_vld_d;
  logic [RowW-1:0]   pf_q, pf_d;
  logic              pf_vld_q, pf_vld_d;
  logic              beat, consume, issue;

  always_comb begin
    state_d     = state_q;
    c_index_d   = c_index_q;
    next_idx_d  = next_idx_q;
    issue_cnt_d = issue_cnt_q;
    rows_left_d = rows_left_q;
    committed_d = committed_q;
    rd_d        = 1'b0;
    dv_d        = rd_q;
    shift_d     = shift_q;
    lane_d      = lane_q;
    shift_vld_d = shift_vld_q;
    pf_d        = pf_q;
    pf_vld_d    = pf_vld_q;

    beat    = shift_vld_q & bus.out_ready;
    consume = beat & (lane_q == 2'd3);
    // Issue only if the returning row is sure to find a register free.
    issue   = ((state_q == StFill) || (state_q == StStream)) && (issue_cnt_q != '0) &&
              ((committed_q - {1'b0, consume}) < 2'd2);

    if (issue) begin
      c_index_d   = next_idx_q;
      next_idx_d  = next_idx_q + IDX_W'(1);
      issue_cnt_d = issue_cnt_q - IDX_W'(1);
      rd_d        = 1'b1;
    end
    if ((state_q == StFill) || (state_q == StStream)) begin
      committed_d = committed_q + {1'b0, issue} - {1'b0, consume};
    end
    if (consume) begin
      rows_left_d = rows_left_q - IDX_W'(1);
    end

    // Output shift register: the top lane is always the current beat.
    if (beat) begin
      shift_d = {shift_q[RowW-LaneW-1:0], {LaneW{1'b0}}};
      lane_d  = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        if (pf_vld_q) begin
          shift_d  = pf_q;
          pf_vld_d = 1'b0;
        end else begin
          shift_vld_d = 1'b0;
        end
      end
    end
    if (dv_q) begin
      if (!shift_vld_d) begin
        shift_d     = bus.C_data_out;
        shift_vld_d = 1'b1;
        lane_d      = 2'd0;
      end else begin
        pf_d     = bus.C_data_out;
        pf_vld_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StFinish: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d     = StFill;
          rows_left_d = bus.row_count;
          if (bus.row_count != '0) begin
            c_index_d   = bus.base_index;
            next_idx_d  = bus.base_index + IDX_W'(1);
            issue_cnt_d = bus.row_count - IDX_W'(1);
            rd_d        = 1'b1;
            committed_d = 2'd1;
          end
        end
      end
      StFill: begin
        if (rows_left_q == '0) begin
          state_d = StFinish;
        end else if (dv_q) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (consume && (rows_left_q == IDX_W'(1))) begin
          state_d = StFinish;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      c_index_q   <= '0;
      next_idx_q  <= '0;
      issue_cnt_q <= '0;
      rows_left_q <= '0;
      committed_q <= '0;
      rd_q        <= 1'b0;
      dv_q        <= 1'b0;
      shift_q     <= '0;
      lane_q      <= '0;
      shift_vld_q <= 1'b0;
      pf_q        <= '0;
      pf_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_index_q   <= c_index_d;
      next_idx_q  <= next_idx_d;
      issue_cnt_q <= issue_cnt_d;
      rows_left_q <= rows_left_d;
      committed_q <= committed_d;
      rd_q        <= rd_d;
      dv_q        <= dv_d;
      shift_q     <= shift_d;
      lane_q      <= lane_d;
      shift_vld_q <= shift_vld_d;
      pf_q        <= pf_d;
      pf_vld_q    <= pf_vld_d;
    end
  end

  assign bus.busy      = (state_q == StFill) || (state_q == StStream);
  assign bus.done      = (state_q == StFinish);
  assign bus.C_wr_en   = 1'b0;
  assign bus.C_data_in = '0;
  assign bus.C_index   = c_index_q;
  assign bus.out_valid = shift_vld_q;
  assign bus.out_data  = shift_q[RowW-1 -: LaneW];
  assign bus.out_last  = shift_vld_q && (lane_q == 2'd3) && (rows_left_q == IDX_W'(1));
endmodule

// File: tb/tb_c_buffer_drain.sv
module tb_c_buffer_drain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c_buffer_drain_if bus ();
  c_buffer_drain u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] salt = '0;
  int          ready_mode = 0;
  bit          force_low = 0;
  bit          allow_done = 0;
  logic [15:0] mon_base = '0;
  logic [15:0] mon_count = '0;
  logic [15:0] model_cidx = '0;
  int          rows_acc, beats_acc, done_cnt, first_cyc, last_cyc;
  bit          any_valid, pend_done, stalled;
  logic [31:0] held_d;
  logic        held_l;
  logic [15:0] ahead;
  logic [3:0]  pat = 4'b1001;
  logic [1:0]  ph = '0;

  // Reference buffer contents: lane k of row i = 0x11111111*(k+1) + i*0x01010101, xor salt.
  function automatic logic [127:0] row_of(input logic [15:0] idx);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      r[127-32*k -: 32] = (32'h11111111 * 32'(k + 1) + {16'b0, idx} * 32'h01010101) ^ salt;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous read buffer: data for C_index appears one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.C_data_out <= row_of(bus.C_index);
  end

  always @(posedge clk) begin
    #2;
    if (force_low) bus.out_ready = 1'b0;
    else if (ready_mode == 0) bus.out_ready = 1'b1;
    else if (ready_mode == 1) begin
      bus.out_ready = pat[ph];
      ph = ph + 2'd1;
    end else bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled   = 0;
      pend_done = 0;
    end else begin
      check("C_wr_en", {bus.C_wr_en, bus.C_data_in}, '0);
      if (pend_done) begin
        check("done_after_last", {bus.done, bus.busy}, 2'b10);
        pend_done = 0;
      end else if (bus.done && !allow_done) begin
        check("unexpected_done", bus.done, 1'b0);
      end
      if (bus.done) done_cnt++;
      if (stalled) begin
        check("stall_hold", {bus.out_valid, bus.out_data, bus.out_last}, {1'b1, held_d, held_l});
      end
      if (bus.busy && mon_count != 0) begin
        ahead = bus.C_index - (mon_base + 16'(rows_acc));
        check("lookahead", ahead <= 16'd2, 1'b1);
      end
      if (bus.out_valid) any_valid = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.out_data, 'x);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", bus.out_data, mon_e.d);
          check("beat_last", bus.out_last, mon_e.l);
          if (mon_e.l) pend_done = 1;
        end
        beats_acc++;
        if (beats_acc % 4 == 0) rows_acc++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_l  = bus.out_last;
    end
  end

  task automatic prep(input logic [15:0] base, input logic [15:0] cnt);
    logic [127:0] row;
    for (int r = 0; r < int'(cnt); r++) begin
      row = row_of(base + 16'(r));
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({row[127-32*k -: 32], (r == int'(cnt) - 1) && (k == 3)});
      end
    end
    mon_base = base; mon_count = cnt; rows_acc = 0; beats_acc = 0;
    first_cyc = -1; last_cyc = -1; done_cnt = 0; any_valid = 0;
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] cnt);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_index = base; bus.row_count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_index = 16'($urandom); bus.row_count = 16'($urandom);
  endtask

  task automatic run_drain(input logic [15:0] base, input logic [15:0] cnt, input int mode,
                           input bit repulse);
    int n;
    ready_mode = mode;
    prep(base, cnt);
    pulse_start(base, cnt);
    @(negedge clk);
    check("start_busy_index", {bus.busy, bus.C_index}, {1'b1, base});
    @(negedge clk);
    check("valid_n2", bus.out_valid, 1'b0);
    @(negedge clk);
    check("valid_n3", bus.out_valid, 1'b1);
    if (repulse) begin
      bus.start = 1'b1; bus.base_index = 16'h0100; bus.row_count = 16'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done_seen", done_cnt > 0, 1'b1);
    repeat (4) @(posedge clk);
    check("single_done", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
    if (mode == 0) check("continuous_beats", last_cyc - first_cyc, 4 * int'(cnt) - 1);
    exp_q.delete();
    model_cidx = base + cnt - 16'd1;
  endtask

  task automatic run_zero(input logic [15:0] base);
    allow_done = 1;
    prep(base, 16'd0);
    pulse_start(base, 16'd0);
    @(negedge clk);
    check("zero_busy", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    check("zero_done", {bus.busy, bus.done}, 2'b01);
    check("zero_cindex", bus.C_index, model_cidx);
    @(negedge clk);
    check("zero_after", {bus.busy, bus.done}, 2'b00);
    repeat (4) @(negedge clk);
    check("zero_no_valid", any_valid, 1'b0);
    allow_done = 0;
  endtask

  task automatic run_abort();
    int n;
    ready_mode = 0;
    prep(16'h0020, 16'd4);
    pulse_start(16'h0020, 16'd4);
    n = 0;
    while (beats_acc < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("abort_reached_beat5", beats_acc >= 5, 1'b1);
    #1;
    rst_n = 1'b0; force_low = 1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_reset_outs",
          {bus.busy, bus.done, bus.out_valid, bus.out_last, bus.C_wr_en, bus.C_index,
           bus.out_data}, '0);
    model_cidx = '0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    force_low = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_index = '0; bus.row_count = '0; bus.out_ready = 1'b1;
    bus.C_data_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {bus.busy, bus.done, bus.out_valid, bus.out_last, bus.C_wr_en, bus.C_index,
           bus.out_data}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_drain(16'h0000, 16'd3, 0, 0);
    run_drain(16'h0000, 16'd3, 1, 0);
    run_drain(16'hFFFF, 16'd2, 0, 0);
    run_zero(16'h1234);
    run_abort();
    run_drain(16'h0000, 16'd4, 0, 0);
    run_drain(16'h0000, 16'd2, 0, 1);
    for (int t = 0; t < 6; t++) begin
      salt = $urandom;
      run_drain(16'($urandom), 16'($urandom_range(1, 6)), 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/c_buffer_drain.md
Name: c_buffer_drain

Overview:
- Reader for the C global buffer: after the systolic array has written its 128-bit result rows, this block reads them back and serialises each row into four 32-bit words on a valid/ready output stream toward the host or testbench.
- Sits beside the systolic array on the C buffer port and only runs when the array is idle.
- Issues reads only: C_wr_en is held at 0 at all times.
- Prefetches the next row so that, with the sink always ready, it sustains one output beat per cycle.

Parameters:
- IDX_W, 16, width of the C buffer index and of the row count.
- LANES, 4, number of 32-bit lanes per C row; fixed at 4 and not re-parameterisable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse that begins a drain; sampled only when busy=0
- base_index  input  16  first C row index; sampled with start
- row_count  input  16  number of 128-bit rows to drain; sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the last beat has been accepted
- C_wr_en  output  1  constant 0
- C_index  output  16  registered read address
- C_data_in  output  128  constant 0
- C_data_out  input  128  buffer read data; valid the cycle after C_index is presented
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready
- out_data  output  32  stream data
- out_last  output  1  high on the final beat of the whole drain

Behaviour:
- Reset (synchronous, rst_n=0 at a clock edge):
  - busy, done, out_valid, out_last, C_wr_en = 0; C_index = 0; out_data = 0.
  - All internal counters and valid flags are cleared.
  - Reset mid-drain abandons the transfer immediately: no further beats and no done pulse.
- Stream handshake:
  - A beat transfers on a cycle where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- Lane order:
  - Beat 0 = C_data_out[127:96], beat 1 = [95:64], beat 2 = [63:32], beat 3 = [31:0].
- Read issue:
  - Rows are read at base_index, base_index+1, … up to base_index+row_count-1.
  - Index arithmetic is modulo 2^16; wrap past 0xFFFF goes to 0x0000.
  - Read latency is exactly 1 cycle: C_index presented in cycle t gives data in cycle t+1, which is captured at the end of t+1.
- Buffering:
  - One 128-bit output shift register with a 2-bit lane counter.
  - One 128-bit prefetch register with a valid flag.
  - A read is issued only if its data is guaranteed a free slot on return, i.e. the prefetch register is empty or will be consumed in the same cycle. No read data is ever dropped.
  - When the last lane of the shift register is accepted and the prefetch is valid, the prefetch moves into the shift register in that cycle. The next beat is then valid in the following cycle with no bubble.
- States:
  - IDLE: wait for start.
  - FILL: first read is in flight.
  - STREAM: beats flowing, further reads issued as slots free.
  - FINISH: one cycle that asserts done, then back to IDLE.
- Latency:
  - start accepted at edge n → busy=1 and C_index=base_index from cycle n+1.
  - Data returns in cycle n+2; out_valid=1 with beat 0 from cycle n+3.
  - With out_ready held high, beats are continuous: 4×row_count beats in 4×row_count consecutive cycles.
- Completion:
  - out_last=1 only on beat 3 of the final row.
  - On its acceptance, done=1 in the next cycle; busy falls in that same cycle.
- row_count=0: start causes busy=1 for one cycle, then done=1 and busy=0 in the following cycle. No read is issued and out_valid stays 0.
- A start pulse while busy=1 is ignored and has no effect on the running drain.

Test Plan:
- Rows 0..2 hold the four lanes (0x11111111, 0x22222222, 0x33333333, 0x44444444) + row×0x01010101; base_index=0, row_count=3, out_ready=1 → 12 consecutive beats starting cycle n+3, in order 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x12121212, …, 0x46464646; out_last only on beat 12; done one cycle later.
- Same data, out_ready toggled 1,0,0,1 repeating → identical 12-beat sequence; out_data and out_last stable during every stall; C_index never runs more than two rows ahead of the row being streamed.
- base_index=0xFFFF, row_count=2 → C_index sequence 0xFFFF then 0x0000; 8 beats taken from those two rows.
- row_count=0 → busy high for exactly 1 cycle, done pulse, out_valid never asserted, C_index unchanged.
- Drain of 4 rows with rst_n pulled low after beat 5 → next cycle all outputs at reset values, no done. A fresh start afterwards drains correctly from beat 0.
- start re-pulsed with base_index=0x0100 during a running drain of row_count=2 → ignored; original 8 beats delivered and a single done pulse.
